// File: rtl/dbus_pkg.sv
// Shared definitions for the data bus responder: RISC-V load/store func3 codes,
// responder FSM states and the byte-lane count of a RAM word.
package dbus_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam int BE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    RESP
  } state_t;

endpackage

// File: rtl/dbus_ram.sv
// Single-port word-organised data RAM with per-byte write enables and a
// registered read port; contents are never cleared.
module dbus_ram
  import dbus_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [BE_W-1:0]                be,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int b = 0; b < BE_W; b++) begin
      if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/data_bus_responder.sv
// Memory-side data bus responder: one load/store in flight, byte/half/word access.
// Define DBUS_RESP_ERR_EN to enable request checking and the o_Err response.
module data_bus_responder
  import dbus_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Re,
  input  logic        i_We,
  input  logic [31:0] i_Addr,
  input  logic [31:0] i_WData,
  input  logic [2:0]  i_Func3,
  output logic        o_Ready,
  output logic        o_Done,
  output logic [31:0] o_RData,
  output logic        o_Err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [2:0] WAIT_LAST = 3'(WAIT_STATES - 1);

  state_t          state_q, state_d;
  logic [2:0]      wait_cnt;
  logic            accept, req_err;
  logic [1:0]      req_size, req_off;
  logic            store_q, unsigned_q, err_q;
  logic [1:0]      size_q, off_q;
  logic [AW-1:0]   index_q;
  logic [31:0]     wdata_q, ram_wdata, ram_rdata, load_val;
  logic [BE_W-1:0] lane_be, ram_be;
  logic [7:0]      byte_lane;
  logic [15:0]     half_lane;

  assign o_Ready = (state_q == IDLE) & ~i_Rst;
  assign accept  = (i_Re | i_We) & o_Ready;

  // Size codes: 0 byte, 1 half, 2 word; unknown func3 falls back to word.
  always_comb begin
    req_size = 2'd2;
    if (i_We) begin
      if (i_Func3 == SB)      req_size = 2'd0;
      else if (i_Func3 == SH) req_size = 2'd1;
    end else begin
      if (i_Func3 inside {LB, LBU})      req_size = 2'd0;
      else if (i_Func3 inside {LH, LHU}) req_size = 2'd1;
    end
    case (req_size)
      2'd0:    req_off = i_Addr[1:0];
      2'd1:    req_off = {i_Addr[1], 1'b0};
      default: req_off = 2'b00;
    endcase
`ifdef DBUS_RESP_ERR_EN
    req_err = (i_Re & i_We)
            | (i_We ? !(i_Func3 inside {SB, SH, SW}) : !(i_Func3 inside {LB, LH, LW, LBU, LHU}))
            | ((req_size == 2'd1) & i_Addr[0])
            | ((req_size == 2'd2) & (i_Addr[1:0] != 2'b00))
            | (|i_Addr[31:AW+2]);
`else
    req_err = 1'b0;
`endif
  end

`ifndef DBUS_RESP_ERR_EN
  logic addr_hi_unused;
  assign addr_hi_unused = |i_Addr[31:AW+2];
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = req_err ? RESP : ((WAIT_STATES > 0) ? WAIT : ACCESS);
      WAIT:    if (wait_cnt == WAIT_LAST) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q  <= IDLE;
      wait_cnt <= 3'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_cnt <= (state_q == WAIT) ? wait_cnt + 3'd1 : 3'd0;
      if (accept) err_q <= req_err;
    end
  end

  // Request fields are held for the whole transaction so the bus may move on.
  always_ff @(posedge i_Clk) begin
    if (accept) begin
      store_q    <= i_We;
      unsigned_q <= i_Func3[2];
      size_q     <= req_size;
      off_q      <= req_off;
      index_q    <= i_Addr[AW+1:2];
      wdata_q    <= i_WData;
    end
  end

  always_comb begin
    case (size_q)
      2'd0: begin
        ram_wdata = {4{wdata_q[7:0]}};
        lane_be   = 4'b0001 << off_q;
      end
      2'd1: begin
        ram_wdata = {2{wdata_q[15:0]}};
        lane_be   = 4'b0011 << off_q;
      end
      default: begin
        ram_wdata = wdata_q;
        lane_be   = 4'b1111;
      end
    endcase
    ram_be = (state_q == ACCESS && store_q && !i_Rst) ? lane_be : '0;
  end

  dbus_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk  (i_Clk),
    .addr (index_q),
    .be   (ram_be),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  // Read data was captured at the end of ACCESS; extension uses the held size/offset.
  always_comb begin
    byte_lane = ram_rdata[{off_q, 3'b000} +: 8];
    half_lane = ram_rdata[{off_q[1], 4'b0000} +: 16];
    case (size_q)
      2'd0:    load_val = unsigned_q ? {24'd0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      2'd1:    load_val = unsigned_q ? {16'd0, half_lane} : {{16{half_lane[15]}}, half_lane};
      default: load_val = ram_rdata;
    endcase
  end

  assign o_Done  = (state_q == RESP) & ~i_Rst;
  assign o_RData = (o_Done & ~store_q & ~err_q) ? load_val : 32'd0;
`ifdef DBUS_RESP_ERR_EN
  assign o_Err   = o_Done & err_q;
`else
  assign o_Err   = 1'b0;
`endif

endmodule

// File: doc/data_bus_responder.md
# data_bus_responder

Memory-side responder for the CPU data bus: accepts load/store requests issued under the decoder's DBusRe/DBusWe/func3 control, and performs byte/half/word accesses on an internal word-organised data RAM. Loads return sign- or zero-extended data; stores update only the addressed bytes. Requests are size-checked and range-checked. Sits between the CPU memory stage and the data RAM, one request in flight.

## Interface
- DEPTH_WORDS, 1024: RAM depth in 32-bit words; power of two.
- WAIT_STATES, 1: extra cycles inserted before the RAM access; 0..7.
- i_Clk  in  1  sole clock; all logic on rising edge.
- i_Rst  in  1  synchronous, active-high reset.
- i_Re  in  1  load request.
- i_We  in  1  store request.
- i_Addr  in  32  byte address.
- i_WData  in  32  store data, right-aligned (SB uses [7:0], SH uses [15:0]).
- i_Func3  in  3  access size/sign, RISC-V load/store func3.
- o_Ready  out  1  request may be accepted this cycle.
- o_Done  out  1  one-cycle completion pulse for loads and stores.
- o_RData  out  32  load result, valid with o_Done on a load; 0 otherwise.
- o_Err  out  1  request rejected; valid with o_Done.

## Operation
- Accept when (i_Re | i_We) & o_Ready. i_Addr, i_WData, i_Func3, i_Re and i_We are latched on acceptance and may change afterwards.
- o_Ready = (state == IDLE) & !i_Rst.
- States:
  - IDLE → WAIT on accept if WAIT_STATES > 0; else → ACCESS.
  - WAIT counts WAIT_STATES cycles → ACCESS.
  - ACCESS → RESP.
  - RESP → IDLE.
  - An errored request goes IDLE → RESP directly and never touches RAM.
- Func3 decoding:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is illegal.
- Error conditions: i_Re & i_We together; illegal func3; halfword with addr[0]=1; word with addr[1:0]≠0; word index addr[31:2] ≥ DEPTH_WORDS.
- Store byte enables:
  - SB: 4'b0001 << addr[1:0].
  - SH: 4'b0011 << addr[1:0].
  - SW: 4'b1111.
  - Write data is replicated into each byte lane.
- Loads: byte/half selected by addr[1:0]; LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- Reset:
  - Outputs: o_Done=0, o_Err=0, o_RData=0, state IDLE.
  - Reset during WAIT discards the request; no write occurs.
  - Reset coincident with ACCESS blocks the write.
  - RAM contents are never cleared by reset.

## Timing
- Accept at cycle 0. RAM read/write in cycle WAIT_STATES+1. o_Done high in cycle WAIT_STATES+2, for exactly one cycle.
- Errored request: o_Done and o_Err high in cycle 1.
- o_Ready is low from cycle 1 through the o_Done cycle. The next accept is possible the cycle after o_Done, so throughput is one request per WAIT_STATES+3 cycles.
- o_RData and o_Err are registered and change only in the RESP cycle; they are 0 in all other cycles.
- A store followed immediately by a load to the same word returns the new data.

## Configuration
- DBUS_RESP_ERR_EN defined:
  - All error checks are active; o_Err is driven.
  - An errored request performs no RAM access. A load error returns o_RData=0.
- DBUS_RESP_ERR_EN undefined:
  - o_Err is tied 0 and no checks are made.
  - Misaligned accesses are force-aligned: low address bits are ignored for half/word.
  - Out-of-range word indices wrap modulo DEPTH_WORDS.
  - Illegal func3 is treated as word size.
  - Simultaneous i_Re & i_We is treated as a store.
  - Every request takes the full WAIT/ACCESS/RESP path.

## Structure
- Shared package dbus_pkg:
  - func3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW).
  - State enum (IDLE, WAIT, ACCESS, RESP).
  - Byte-enable width constant (4).
- One sub-module, dbus_ram:
  - DEPTH_WORDS × 32 synchronous RAM with 4-bit byte-write enables.
  - Single port; registered read data.
- FSM, wait counter, checks and extension logic live in data_bus_responder.

## Test plan
- SW addr 0x10 data 0xDEADBEEF, WAIT_STATES=1, then LW 0x10 → o_Done at cycle 3 of each request; o_RData=0xDEADBEEF, o_Err=0.
- SB 0x11 data 0x000000A5 over word 0x00000000, then LB 0x11 → 0xFFFFFFA5; LBU 0x11 → 0x000000A5; LW 0x10 → 0x0000A500.
- SH 0x22 data 0x8001, then LH 0x22 → 0xFFFF8001; LHU 0x22 → 0x00008001.
- With ERR_EN: LW 0x13 → o_Err=1 at cycle 1, o_RData=0. LW at word index DEPTH_WORDS → o_Err=1. Re&We together → o_Err=1. In all three cases RAM is unchanged.
- Without ERR_EN: SW 0x13 data 0x12345678, then LW 0x10 → 0x12345678, o_Err=0.
- SW 0x40 data 0x55555555 with i_Rst asserted in the WAIT cycle; then LW 0x40 → prior contents. o_Ready=0 while i_Rst=1 and =1 the cycle after.
